// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles LSB-first into NIBBLES-wide words on a valid/ready port.
// in_last closes a partial word early; word_cnt counts words handed off since reset.
module nibble_packer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [3:0]                       in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [4*NIBBLES-1:0]             out_data,
  output logic [$clog2(NIBBLES+1)-1:0]     out_count,
  output logic [15:0]                      word_cnt
);

  localparam int unsigned WW = 4 * NIBBLES;
  localparam int unsigned AW = 4 * (NIBBLES - 1);
  localparam int unsigned IW = $clog2(NIBBLES);
  localparam int unsigned CW = $clog2(NIBBLES + 1);

  logic [IW-1:0] idx;
  logic [AW-1:0] acc;
  logic          accept;
  logic          complete;
  logic          handoff;
  logic [WW-1:0] word;
  logic [AW-1:0] acc_ins;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (idx == IW'(NIBBLES - 1)));
  assign handoff  = out_valid && out_ready;

  // acc slots at or above idx are always zero, so OR-ing the new nibble in is enough
  always_comb begin
    word    = {4'b0000, acc} | (WW'(in_data) << {idx, 2'b00});
    acc_ins = acc | (AW'(in_data) << {idx, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      word_cnt  <= '0;
    end else begin
      if (handoff) begin
        word_cnt  <= word_cnt + 16'd1;
        out_valid <= 1'b0;
      end
      // a completing accept overrides the drop above, giving bubble-free back-to-back words
      if (complete) begin
        out_data  <= word;
        out_count <= CW'(idx) + CW'(1);
        out_valid <= 1'b1;
        idx       <= '0;
        acc       <= '0;
      end else if (accept) begin
        acc <= acc_ins;
        idx <= idx + IW'(1);
      end
    end
  end

endmodule
